// File: rtl/x_ram_noread.sv
// x_ram_noread
// Horizontal-position engine for the four scrolling pipes of the Flappy game.
// Holds the left/right X edges of pipes 0-3, scrolls them one pixel left every
// MOVE_DIV clocks while the game runs, recycles a pipe to the far right once
// its left edge has reached 0, and counts recycled pipes as the score.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous active-high reset, highest priority
//   Start        level, leaves INITIAL for COUNT
//   Ack          level, leaves STOP for INITIAL
//   out_pipe     index of the most recently recycled pipe
//   Score        number of recycled pipes, saturates at SCORE_MAX
//   X_Edge_Ox_L  left edge of pipe x
//   X_Edge_Ox_R  right edge of pipe x (left edge + PIPE_W)
//   Q_Initial, Q_Count, Q_Stop  one-hot registered state flags
module x_ram_noread #(
  parameter int PIPE_W    = 60,
  parameter int SPACING   = 160,
  parameter int MOVE_DIV  = 1,
  parameter int SCORE_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Start,
  input  logic       Ack,
  output logic [1:0] out_pipe,
  output logic [3:0] Score,
  output logic [9:0] X_Edge_OO_L,
  output logic [9:0] X_Edge_O1_L,
  output logic [9:0] X_Edge_O2_L,
  output logic [9:0] X_Edge_O3_L,
  output logic [9:0] X_Edge_OO_R,
  output logic [9:0] X_Edge_O1_R,
  output logic [9:0] X_Edge_O2_R,
  output logic [9:0] X_Edge_O3_R,
  output logic       Q_Initial,
  output logic       Q_Count,
  output logic       Q_Stop
);

  localparam int               DIV_W     = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(MOVE_DIV - 1);
  localparam logic [9:0]       WRAP_L    = 10'(4 * SPACING);
  localparam logic [9:0]       PIPE_W_10 = 10'(PIPE_W);
  localparam logic [3:0]       SCORE_TOP = 4'(SCORE_MAX);

  // One-hot encoding so the state register bits double as the Q_* flags.
  typedef enum logic [2:0] {
    S_INITIAL = 3'b001,
    S_COUNT   = 3'b010,
    S_STOP    = 3'b100
  } state_t;

  state_t           state;
  logic [9:0]       l_edge [4];
  logic [9:0]       l_step [4];
  logic [DIV_W-1:0] div_cnt;
  logic             any_wrap;
  logic [1:0]       wrap_idx;
  logic [3:0]       score_step;
  logic             move_step;

  function automatic logic [9:0] init_l(input int idx);
    return 10'((idx + 1) * SPACING);
  endfunction

  // Candidate positions for the next move step. A pipe sitting at 0 is
  // recycled to the far right; with equal spacing at most one pipe does so
  // per step, so a single score increment and index capture suffice.
  always_comb begin
    any_wrap = 1'b0;
    wrap_idx = out_pipe;
    for (int i = 0; i < 4; i++) begin
      if (l_edge[i] == 10'd0) begin
        l_step[i] = WRAP_L;
        any_wrap  = 1'b1;
        wrap_idx  = 2'(i);
      end else begin
        l_step[i] = l_edge[i] - 10'd1;
      end
    end
    score_step = (any_wrap && (Score < SCORE_TOP)) ? Score + 4'd1 : Score;
  end

  assign move_step = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_INITIAL;
      div_cnt  <= '0;
      Score    <= '0;
      out_pipe <= '0;
      for (int i = 0; i < 4; i++) l_edge[i] <= init_l(i);
    end else begin
      case (state)
        // Positions are reloaded every cycle so leaving STOP restores them.
        S_INITIAL: begin
          div_cnt  <= '0;
          Score    <= '0;
          out_pipe <= '0;
          for (int i = 0; i < 4; i++) l_edge[i] <= init_l(i);
          if (Start) state <= S_COUNT;
        end
        S_COUNT: begin
          if (move_step) begin
            div_cnt  <= '0;
            Score    <= score_step;
            out_pipe <= wrap_idx;
            for (int i = 0; i < 4; i++) l_edge[i] <= l_step[i];
            if (score_step == SCORE_TOP) state <= S_STOP;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (Ack) state <= S_INITIAL;
        end
        default: state <= S_INITIAL;
      endcase
    end
  end

  assign X_Edge_OO_L = l_edge[0];
  assign X_Edge_O1_L = l_edge[1];
  assign X_Edge_O2_L = l_edge[2];
  assign X_Edge_O3_L = l_edge[3];

  // Cannot overflow: 4*SPACING + PIPE_W is bounded to fit 10 bits.
  assign X_Edge_OO_R = l_edge[0] + PIPE_W_10;
  assign X_Edge_O1_R = l_edge[1] + PIPE_W_10;
  assign X_Edge_O2_R = l_edge[2] + PIPE_W_10;
  assign X_Edge_O3_R = l_edge[3] + PIPE_W_10;

  assign Q_Initial = state[0];
  assign Q_Count   = state[1];
  assign Q_Stop    = state[2];

endmodule

// File: tb/tb_x_ram_noread.sv
// tb_x_ram_noread
// Self-checking bench for x_ram_noread. The reference model tracks only the
// game phase and the number of move steps taken; every expected output is
// derived in closed form from that step count (modular pipe positions,
// wrap counts per pipe, latest wrapping pipe).
module tb_x_ram_noread;

  localparam int PIPE_W    = 60;
  localparam int SPACING   = 160;
  localparam int MOVE_DIV  = 1;
  localparam int SCORE_MAX = 15;
  // A pipe revisits the same left edge every 4*SPACING+1 steps (640..0).
  localparam int PERIOD    = 4 * SPACING + 1;

  localparam int M_INIT  = 0;
  localparam int M_COUNT = 1;
  localparam int M_STOP  = 2;

  logic       clk;
  logic       reset;
  logic       Start;
  logic       Ack;
  logic [1:0] out_pipe;
  logic [3:0] Score;
  logic [9:0] l0, l1, l2, l3, r0, r1, r2, r3;
  logic       Q_Initial, Q_Count, Q_Stop;
  logic [9:0] lo [4];
  logic [9:0] ro [4];

  int total = 0;
  int bad   = 0;
  int m_state;
  int m_steps;
  int m_cycles;

  x_ram_noread #(
    .PIPE_W(PIPE_W), .SPACING(SPACING), .MOVE_DIV(MOVE_DIV), .SCORE_MAX(SCORE_MAX)
  ) dut (
    .clk(clk), .reset(reset), .Start(Start), .Ack(Ack),
    .out_pipe(out_pipe), .Score(Score),
    .X_Edge_OO_L(l0), .X_Edge_O1_L(l1), .X_Edge_O2_L(l2), .X_Edge_O3_L(l3),
    .X_Edge_OO_R(r0), .X_Edge_O1_R(r1), .X_Edge_O2_R(r2), .X_Edge_O3_R(r3),
    .Q_Initial(Q_Initial), .Q_Count(Q_Count), .Q_Stop(Q_Stop)
  );

  assign lo[0] = l0;
  assign lo[1] = l1;
  assign lo[2] = l2;
  assign lo[3] = l3;
  assign ro[0] = r0;
  assign ro[1] = r1;
  assign ro[2] = r2;
  assign ro[3] = r3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int first_wrap(input int i);
    return (i + 1) * SPACING + 1;
  endfunction

  function automatic int exp_l(input int i, input int n);
    int v;
    v = ((i + 1) * SPACING - n) % PERIOD;
    if (v < 0) v += PERIOD;
    return v;
  endfunction

  function automatic int total_wraps(input int n);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++)
      if (n >= first_wrap(i)) s += (n - first_wrap(i)) / PERIOD + 1;
    return s;
  endfunction

  function automatic int exp_score(input int n);
    int s;
    s = total_wraps(n);
    return (s > SCORE_MAX) ? SCORE_MAX : s;
  endfunction

  function automatic int exp_out(input int n);
    int latest, idx, t;
    latest = -1;
    idx    = 0;
    for (int i = 0; i < 4; i++) begin
      if (n >= first_wrap(i)) begin
        t = first_wrap(i) + ((n - first_wrap(i)) / PERIOD) * PERIOD;
        if (t > latest) begin
          latest = t;
          idx    = i;
        end
      end
    end
    return idx;
  endfunction

  // Advance the phase/step model by one rising edge given the sampled inputs.
  task automatic modelEdge(input logic s, input logic a, input logic r);
    if (r) begin
      m_state = M_INIT; m_steps = 0; m_cycles = 0;
    end else begin
      case (m_state)
        M_INIT: begin
          m_steps = 0; m_cycles = 0;
          if (s) m_state = M_COUNT;
        end
        M_COUNT: begin
          m_cycles++;
          if (m_cycles % MOVE_DIV == 0) begin
            m_steps++;
            if (total_wraps(m_steps) >= SCORE_MAX) m_state = M_STOP;
          end
        end
        default: begin
          if (a) m_state = M_INIT;
        end
      endcase
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic r);
    @(negedge clk);
    Start = s; Ack = a; reset = r;
    @(posedge clk);
    modelEdge(s, a, r);
    #1;
  endtask

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      $error("[TB] check %s", tag);
    end
  endtask

  task automatic checkOutput();
    logic [2:0] flags;
    flags = {m_state == M_INIT, m_state == M_COUNT, m_state == M_STOP};
    checkOne("flags", {29'd0, Q_Initial, Q_Count, Q_Stop}, {29'd0, flags});
    checkOne("score", {28'd0, Score}, exp_score(m_steps));
    checkOne("out_pipe", {30'd0, out_pipe}, exp_out(m_steps));
    for (int i = 0; i < 4; i++) begin
      checkOne($sformatf("L%0d", i), {22'd0, lo[i]}, exp_l(i, m_steps));
      checkOne($sformatf("R%0d", i), {22'd0, ro[i]}, exp_l(i, m_steps) + PIPE_W);
    end
  endtask

  task automatic runToStop(input int budget);
    for (int k = 0; k < budget && m_state != M_STOP; k++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 7) == 0), 1'b0);
      checkOutput();
    end
    checkOne("reached_stop", {31'd0, Q_Stop}, 1);
  endtask

  initial begin
    Start = 1'b0; Ack = 1'b0; reset = 1'b1;
    m_state = M_INIT; m_steps = 0; m_cycles = 0;

    // Reset and idle in INITIAL with stray Ack pulses.
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput();
    checkOne("rst_L3", {22'd0, l3}, 640);
    checkOne("rst_R3", {22'd0, r3}, 700);
    repeat ($urandom_range(3, 8)) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      checkOutput();
    end

    // Start together with Ack: Start wins in INITIAL, edges unchanged at E0.
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput();
    checkOne("start_L0", {22'd0, l0}, 160);
    repeat (12) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      checkOutput();
    end
    checkOne("c12_L0", {22'd0, l0}, 148);
    checkOne("c12_L3", {22'd0, l3}, 628);
    checkOne("c12_R0", {22'd0, r0}, 208);

    // Long run to STOP with directed spot checks at the first two wraps.
    for (int k = 0; k < 6000 && m_state != M_STOP; k++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 7) == 0), 1'b0);
      checkOutput();
      if (m_steps == 160) checkOne("s160_L0", {22'd0, l0}, 0);
      if (m_steps == 161) begin
        checkOne("s161_L0", {22'd0, l0}, 640);
        checkOne("s161_L1", {22'd0, l1}, 159);
        checkOne("s161_score", {28'd0, Score}, 1);
        checkOne("s161_out", {30'd0, out_pipe}, 0);
      end
      if (m_steps == 321) begin
        checkOne("s321_L1", {22'd0, l1}, 640);
        checkOne("s321_score", {28'd0, Score}, 2);
        checkOne("s321_out", {30'd0, out_pipe}, 1);
      end
    end
    checkOne("stop_flag", {31'd0, Q_Stop}, 1);
    checkOne("stop_score", {28'd0, Score}, 15);
    checkOne("stop_out", {30'd0, out_pipe}, 2);

    // Frozen in STOP; Start must not disturb anything.
    repeat (20) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      checkOutput();
    end

    // Ack: INITIAL next edge, positions restored one edge later.
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput();
    checkOne("ack_init", {31'd0, Q_Initial}, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput();
    checkOne("restore_L0", {22'd0, l0}, 160);
    checkOne("restore_score", {28'd0, Score}, 0);

    // Reset in the middle of COUNT.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput();
    repeat ($urandom_range(20, 400)) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      checkOutput();
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput();
    checkOne("rstc_L0", {22'd0, l0}, 160);
    checkOne("rstc_init", {31'd0, Q_Initial}, 1);

    // Reset in the middle of STOP.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput();
    runToStop(6000);
    repeat ($urandom_range(1, 10)) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput();
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput();
    checkOne("rsts_score", {28'd0, Score}, 0);
    checkOne("rsts_R2", {22'd0, r2}, 540);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
